// File: rtl/ex_stage.sv
// uP16 execute stage: single-cycle ALU, iterative shift-add multiplier,
// memory-stage request drive and the EX/MEM pipeline register.
module ex_stage #(
   parameter int DSIZE = 16,
   parameter int MADDR = 10,
   parameter int RSIZE = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             valid_in,
   input  logic             flush,
   input  logic [3:0]       aluOp,
   input  logic [DSIZE-1:0] operandA,
   input  logic [DSIZE-1:0] operandB,
   input  logic [DSIZE-1:0] storeData,
   input  logic             memWriteEnab_in,
   input  logic             memEnab_in,
   input  logic             sel_mem2reg_in,
   input  logic             regWrite_in,
   input  logic [RSIZE-1:0] writeReg_in,
   output logic [DSIZE-1:0] ALUResult,
   output logic [MADDR-1:0] ALUResult_mem,
   output logic [DSIZE-1:0] readData1,
   output logic             memWriteEnab,
   output logic             memEnab,
   output logic             sel_mem2reg,
   output logic             regWrite,
   output logic [RSIZE-1:0] writeReg,
   output logic             zeroFlag,
   output logic             stall
);

   localparam int         CW     = $clog2(DSIZE);
   localparam logic [3:0] OP_MUL = 4'd9;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   typedef struct packed {
      logic [DSIZE-1:0] alu;
      logic             zero;
      logic             sel_mem2reg;
      logic             regWrite;
      logic [RSIZE-1:0] writeReg;
   } exmem_t;

   state_t           r_state, w_state_nxt;
   logic [DSIZE-1:0] r_mA, r_mB, r_acc;
   logic [CW-1:0]    r_cnt;
   exmem_t           r_exmem;

   logic             w_live, w_is_mul, w_start, w_stall;
   logic [DSIZE-1:0] w_alu;

   assign w_live   = valid_in & ~flush;
   assign w_is_mul = (aluOp == OP_MUL);

   always_comb begin
      w_alu = '0;
      case (aluOp)
         4'd0:    w_alu = operandA + operandB;
         4'd1:    w_alu = operandA - operandB;
         4'd2:    w_alu = operandA & operandB;
         4'd3:    w_alu = operandA | operandB;
         4'd4:    w_alu = operandA ^ operandB;
         4'd5:    w_alu = ~operandA;
         4'd6:    w_alu = operandA << operandB[3:0];
         4'd7:    w_alu = operandA >> operandB[3:0];
         4'd8:    w_alu = $signed(operandA) >>> operandB[3:0];
         4'd9:    w_alu = r_acc;
         4'd10:   w_alu = operandB;
         default: w_alu = '0;
      endcase
   end

   // Flush wins over an in-flight multiply: stall drops in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_live && w_is_mul) begin
               w_start     = 1'b1;
               w_stall     = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (flush) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_stall = 1'b1;
               if (r_cnt == CW'(DSIZE-1)) w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= S_IDLE;
         r_mA    <= '0;
         r_mB    <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_mA  <= operandA;
            r_mB  <= operandB;
            r_acc <= '0;
            r_cnt <= '0;
         end else if (r_state == S_BUSY) begin
            if (r_mB[0]) r_acc <= r_acc + r_mA;
            r_mA  <= r_mA << 1;
            r_mB  <= r_mB >> 1;
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // While stalled only the control bits are killed; data fields hold.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_exmem <= '0;
      end else if (w_stall) begin
         r_exmem.regWrite    <= 1'b0;
         r_exmem.sel_mem2reg <= 1'b0;
      end else begin
         r_exmem.alu         <= w_alu;
         r_exmem.zero        <= (w_alu == '0);
         r_exmem.sel_mem2reg <= sel_mem2reg_in & w_live;
         r_exmem.regWrite    <= regWrite_in & w_live;
         r_exmem.writeReg    <= writeReg_in;
      end
   end

   assign ALUResult     = r_exmem.alu;
   assign zeroFlag      = r_exmem.zero;
   assign sel_mem2reg   = r_exmem.sel_mem2reg;
   assign regWrite      = r_exmem.regWrite;
   assign writeReg      = r_exmem.writeReg;

   assign ALUResult_mem = w_alu[MADDR-1:0];
   assign readData1     = storeData;
   assign memEnab       = w_live & memEnab_in & ~w_is_mul;
   assign memWriteEnab  = memEnab & memWriteEnab_in;
   assign stall         = w_stall;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: cycle-level reference model plus literal checks.
module tb_ex_stage;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        valid_in = 1'b0, flush = 1'b0;
   logic [3:0]  aluOp = 4'd0;
   logic [15:0] operandA = '0, operandB = '0, storeData = '0;
   logic        memWriteEnab_in = 1'b0, memEnab_in = 1'b0;
   logic        sel_mem2reg_in = 1'b0, regWrite_in = 1'b0;
   logic [3:0]  writeReg_in = '0;
   logic [15:0] ALUResult, readData1;
   logic [9:0]  ALUResult_mem;
   logic        memWriteEnab, memEnab, sel_mem2reg, regWrite, zeroFlag, stall;
   logic [3:0]  writeReg;

   int total = 0;
   int bad   = 0;

   ex_stage #(.DSIZE(16), .MADDR(10), .RSIZE(4)) dut (
      .Clk(Clk), .Rst(Rst), .valid_in(valid_in), .flush(flush), .aluOp(aluOp),
      .operandA(operandA), .operandB(operandB), .storeData(storeData),
      .memWriteEnab_in(memWriteEnab_in), .memEnab_in(memEnab_in),
      .sel_mem2reg_in(sel_mem2reg_in), .regWrite_in(regWrite_in),
      .writeReg_in(writeReg_in), .ALUResult(ALUResult), .ALUResult_mem(ALUResult_mem),
      .readData1(readData1), .memWriteEnab(memWriteEnab), .memEnab(memEnab),
      .sel_mem2reg(sel_mem2reg), .regWrite(regWrite), .writeReg(writeReg),
      .zeroFlag(zeroFlag), .stall(stall)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_n: -1 when no multiply is outstanding, otherwise cycles since MUL entry
   // (1..16 iterating, 17 = result cycle).
   int          m_n = -1;
   logic [15:0] m_a, m_b;
   logic [15:0] e_alu = '0;
   logic        e_zero = 1'b0, e_rw = 1'b0, e_sel = 1'b0, e_known = 1'b1;
   logic [3:0]  e_wr = '0;

   function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ~a;
         4'd6:    return a << b[3:0];
         4'd7:    return a >> b[3:0];
         4'd8:    return $signed(a) >>> b[3:0];
         4'd10:   return b;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic mdl_stall();
      logic live;
      live = valid_in & ~flush;
      if (m_n < 0)   return live && (aluOp == 4'd9);
      if (flush)     return 1'b0;
      return (m_n <= 16);
   endfunction

   always @(posedge Clk) begin
      logic        live, s, kn;
      logic [15:0] r;
      logic [31:0] prod;
      if (Rst) begin
         m_n = -1; e_alu = '0; e_zero = 1'b0; e_rw = 1'b0; e_sel = 1'b0;
         e_wr = '0; e_known = 1'b1;
      end else begin
         live = valid_in & ~flush;
         s    = mdl_stall();
         r    = alu_ref(aluOp, operandA, operandB);
         kn   = (aluOp != 4'd9);
         if (aluOp == 4'd9 && m_n == 17 && !flush) begin
            prod = m_a * m_b;
            r    = prod[15:0];
            kn   = 1'b1;
         end
         if (s) begin
            e_rw = 1'b0; e_sel = 1'b0;
         end else begin
            e_alu = r; e_zero = (r == 16'h0); e_known = kn;
            e_rw = regWrite_in & live; e_sel = sel_mem2reg_in & live; e_wr = writeReg_in;
         end
         if (m_n < 0) begin
            if (live && aluOp == 4'd9) begin
               m_n = 1; m_a = operandA; m_b = operandB;
            end
         end else if (flush || m_n == 17) m_n = -1;
         else m_n++;
      end
   end

   // One compare process, sampling on the falling edge.
   always @(negedge Clk) begin
      logic live, me;
      live = valid_in & ~flush;
      me   = live & memEnab_in & (aluOp != 4'd9);
      chk("stall", stall, mdl_stall());
      chk("memEnab", memEnab, me);
      chk("memWriteEnab", memWriteEnab, me & memWriteEnab_in);
      chk("readData1", readData1, storeData);
      if (aluOp != 4'd9)
         chk("ALUResult_mem", ALUResult_mem, alu_ref(aluOp, operandA, operandB) & 16'h03FF);
      if (e_known) begin
         chk("ALUResult", ALUResult, e_alu);
         chk("zeroFlag", zeroFlag, e_zero);
      end
      chk("regWrite", regWrite, e_rw);
      chk("sel_mem2reg", sel_mem2reg, e_sel);
      chk("writeReg", writeReg, e_wr);
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic z);
      int sc;
      valid_in = 1'b1; aluOp = 4'd9; operandA = a; operandB = b;
      regWrite_in = 1'b1; writeReg_in = 4'd5;
      #1;
      sc = 0;
      while (stall && sc < 30) begin
         sc++;
         step();
         if (sc == 1) chk("mul_bubble_rw", regWrite, 1'b0);
      end
      chk("mul_stall_cycles", sc, 17);
      step();
      chk("mul_result", ALUResult, res);
      chk("mul_zero", zeroFlag, z);
      chk("mul_rw", regWrite, 1'b1);
   endtask

   typedef struct { logic [3:0] op; logic [15:0] exp; } vec_t;

   initial begin
      vec_t tbl[$];
      tbl = '{'{4'd0, 16'h2143}, '{4'd1, 16'h0325}, '{4'd2, 16'h0204}, '{4'd3, 16'h1F3F},
              '{4'd4, 16'h1D3B}, '{4'd5, 16'hEDCB}, '{4'd10, 16'h0F0F}};

      step();
      Rst = 1'b0;
      chk("rst_alu", ALUResult, 16'h0);
      chk("rst_rw", regWrite, 1'b0);
      chk("rst_stall", stall, 1'b0);

      valid_in = 1'b1; aluOp = 4'd0; operandA = 16'h7FFF; operandB = 16'h0001;
      regWrite_in = 1'b1; writeReg_in = 4'd3;
      step();
      chk("add_alu", ALUResult, 16'h8000);
      chk("add_rw", regWrite, 1'b1);
      chk("add_wr", writeReg, 4'd3);
      chk("add_zero", zeroFlag, 1'b0);
      chk("add_stall", stall, 1'b0);

      operandA = 16'h0100; operandB = 16'h0023; storeData = 16'hBEEF;
      memEnab_in = 1'b1; memWriteEnab_in = 1'b1; regWrite_in = 1'b0;
      #1;
      chk("st_addr", ALUResult_mem, 10'h123);
      chk("st_data", readData1, 16'hBEEF);
      chk("st_we", memWriteEnab, 1'b1);
      chk("st_en", memEnab, 1'b1);
      flush = 1'b1;
      #1;
      chk("st_flush_we", memWriteEnab, 1'b0);
      chk("st_flush_en", memEnab, 1'b0);
      step();
      flush = 1'b0; memEnab_in = 1'b0; memWriteEnab_in = 1'b0;

      do_mul(16'h0123, 16'h0045, 16'h4E6F, 1'b0);
      do_mul(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);
      do_mul(16'h0100, 16'h0100, 16'h0000, 1'b1);
      valid_in = 1'b0; aluOp = 4'd0;
      step();

      // flush in the 5th iterating cycle
      valid_in = 1'b1; aluOp = 4'd9; operandA = 16'h0003; operandB = 16'h0005;
      regWrite_in = 1'b1;
      step();
      repeat (4) step();
      flush = 1'b1;
      #1;
      chk("abort_stall", stall, 1'b0);
      step();
      chk("abort_rw", regWrite, 1'b0);
      flush = 1'b0; aluOp = 4'd0; operandA = 16'h0002; operandB = 16'h0003; writeReg_in = 4'd7;
      #1;
      chk("post_abort_stall", stall, 1'b0);
      step();
      chk("post_abort_alu", ALUResult, 16'h0005);
      chk("post_abort_rw", regWrite, 1'b1);

      // reset mid-multiply
      aluOp = 4'd9; operandA = 16'h0003; operandB = 16'h0005;
      step();
      repeat (2) step();
      Rst = 1'b1; valid_in = 1'b0;
      step();
      chk("rstmul_alu", ALUResult, 16'h0);
      chk("rstmul_rw", regWrite, 1'b0);
      chk("rstmul_wr", writeReg, 4'd0);
      chk("rstmul_stall", stall, 1'b0);
      Rst = 1'b0;

      valid_in = 1'b1; operandA = 16'h8001; operandB = 16'h0004; writeReg_in = 4'd2;
      aluOp = 4'd6; step(); chk("shl", ALUResult, 16'h0010);
      aluOp = 4'd7; step(); chk("shr", ALUResult, 16'h0800);
      aluOp = 4'd8; step(); chk("sra", ALUResult, 16'hF800);
      aluOp = 4'd12; step();
      chk("op12_alu", ALUResult, 16'h0000);
      chk("op12_zero", zeroFlag, 1'b1);

      operandA = 16'h1234; operandB = 16'h0F0F;
      foreach (tbl[i]) begin
         aluOp = tbl[i].op;
         step();
         chk($sformatf("op%0d", tbl[i].op), ALUResult, tbl[i].exp);
      end

      valid_in = 1'b0; aluOp = 4'd0; operandA = 16'h0001; operandB = 16'h0001;
      step();
      chk("bubble_alu", ALUResult, 16'h0002);
      chk("bubble_rw", regWrite, 1'b0);

      sel_mem2reg_in = 1'b1; valid_in = 1'b1;
      step();
      chk("sel_live", sel_mem2reg, 1'b1);
      sel_mem2reg_in = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
      $fatal(1, "timeout");
   end

endmodule
